ifu_icache: RTL and testbench

Fully associative, read-only instruction line cache inside the instruction fetch unit (IFU), between the fetch address generator (CPU side) and the instruction memory (memory side). Every cycle it looks up the CPU request address. On a hit it returns the cached instruction line one cycle later. On a miss it issues a tag request to memory, then fills the line from the memory response.

---
 rtl/ifu_icache.sv | 151 +++++++++++++++
 tb/tb_ifu_icache.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifu_icache.sv
// Fully associative read-only instruction line cache with a single
// outstanding miss, fill bypass and round-robin replacement.
module ifu_icache #(
  parameter int NUM_TAGS     = 4,
  parameter int NUM_LINES    = 4,
  parameter int TAG_WIDTH    = 6,
  parameter int LINE_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
  output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
  output logic                  cpu_rspInsLineValidOut,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspInsLineValidIn,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqTagValidOut
);

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  typedef enum logic {IDLE, WAIT} stateT;

  stateT                 stateReg, stateNext;
  logic [TAG_WIDTH-1:0]  pendTagReg, pendTagNext;
  logic [IDX_W-1:0]      rrPtrReg, rrPtrNext;

  logic                  validReg [NUM_TAGS];
  logic [TAG_WIDTH-1:0]  tagReg   [NUM_TAGS];
  logic [LINE_WIDTH-1:0] lineReg  [NUM_LINES];

  logic [TAG_WIDTH-1:0]  reqTag;
  logic [NUM_TAGS-1:0]   hitVec, fillMatchVec, invalidVec;
  logic                  bypass, hit;
  logic [LINE_WIDTH-1:0] hitLine;
  logic [IDX_W-1:0]      victimIdx;
  logic                  matchFound, invalidFound, rrAdvance;

  // Address bits above the tag field are ignored, so such addresses alias.
  assign reqTag = cpu_reqAddrIn[OFFSET_WIDTH+TAG_WIDTH-1:OFFSET_WIDTH];

  generate
    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : gEntry
      assign hitVec[gi]       = validReg[gi] && (tagReg[gi] == reqTag);
      assign fillMatchVec[gi] = validReg[gi] && (tagReg[gi] == mem_rspTagIn);
      assign invalidVec[gi]   = !validReg[gi];
    end
  endgenerate

  // A fill for the looked-up tag in the same cycle counts as a hit.
  assign bypass = mem_rspInsLineValidIn && (mem_rspTagIn == reqTag);
  assign hit    = bypass || (|hitVec);

  // Hit data mux; entries never hold duplicate tags, so OR-ing is safe.
  always_comb begin
    hitLine = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (hitVec[i]) hitLine = hitLine | lineReg[i];
    end
    if (bypass) hitLine = mem_rspInsLineIn;
  end

  // Victim choice: same tag in place, else lowest invalid, else round-robin.
  always_comb begin
    victimIdx    = rrPtrReg;
    matchFound   = 1'b0;
    invalidFound = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (invalidVec[i]) begin
        victimIdx    = IDX_W'(i);
        invalidFound = 1'b1;
      end
    end
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (fillMatchVec[i]) begin
        victimIdx  = IDX_W'(i);
        matchFound = 1'b1;
      end
    end
    rrAdvance = mem_rspInsLineValidIn && !matchFound && !invalidFound;
    rrPtrNext = rrPtrReg;
    if (rrAdvance) begin
      rrPtrNext = (rrPtrReg == IDX_W'(NUM_TAGS - 1)) ? '0 : rrPtrReg + 1'b1;
    end
  end

  // Miss FSM: one outstanding tag request, released by the matching fill.
  always_comb begin
    stateNext   = stateReg;
    pendTagNext = pendTagReg;
    case (stateReg)
      IDLE: begin
        if (!hit) begin
          pendTagNext = reqTag;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rspInsLineValidIn && (mem_rspTagIn == pendTagReg)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Valid bits and replacement pointer, cleared by reset.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_TAGS; i++) validReg[i] <= 1'b0;
      rrPtrReg <= '0;
    end else begin
      if (mem_rspInsLineValidIn) validReg[victimIdx] <= 1'b1;
      rrPtrReg <= rrPtrNext;
    end
  end

  // Tag and line storage; contents are don't-care while invalid.
  always_ff @(posedge Clock) begin
    if (mem_rspInsLineValidIn) begin
      tagReg[victimIdx]  <= mem_rspTagIn;
      lineReg[victimIdx] <= mem_rspInsLineIn;
    end
  end

  // State and registered outputs; on a miss the CPU address/line hold.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      stateReg               <= IDLE;
      pendTagReg             <= '0;
      cpu_rspAddrOut         <= '0;
      cpu_rspInsLineOut      <= '0;
      cpu_rspInsLineValidOut <= 1'b0;
      mem_reqTagOut          <= '0;
      mem_reqTagValidOut     <= 1'b0;
    end else begin
      stateReg               <= stateNext;
      pendTagReg             <= pendTagNext;
      cpu_rspInsLineValidOut <= hit;
      if (hit) begin
        cpu_rspAddrOut    <= cpu_reqAddrIn;
        cpu_rspInsLineOut <= hitLine;
      end
      mem_reqTagOut      <= pendTagNext;
      mem_reqTagValidOut <= (stateNext == WAIT);
    end
  end

endmodule

// File: tb/tb_ifu_icache.sv
// Directed bench for ifu_icache: miss/fill, bypass, replacement, reset.
module tb_ifu_icache;

  logic        Clock;
  logic        Rst;
  logic [31:0] cpu_reqAddrIn;
  logic [31:0] cpu_rspAddrOut;
  logic [31:0] cpu_rspInsLineOut;
  logic        cpu_rspInsLineValidOut;
  logic [5:0]  mem_rspTagIn;
  logic [31:0] mem_rspInsLineIn;
  logic        mem_rspInsLineValidIn;
  logic [5:0]  mem_reqTagOut;
  logic        mem_reqTagValidOut;

  int vecCount  = 0;
  int missCount = 0;

  ifu_icache dut (
    .Clock                  (Clock),
    .Rst                    (Rst),
    .cpu_reqAddrIn          (cpu_reqAddrIn),
    .cpu_rspAddrOut         (cpu_rspAddrOut),
    .cpu_rspInsLineOut      (cpu_rspInsLineOut),
    .cpu_rspInsLineValidOut (cpu_rspInsLineValidOut),
    .mem_rspTagIn           (mem_rspTagIn),
    .mem_rspInsLineIn       (mem_rspInsLineIn),
    .mem_rspInsLineValidIn  (mem_rspInsLineValidIn),
    .mem_reqTagOut          (mem_reqTagOut),
    .mem_reqTagValidOut     (mem_reqTagValidOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkCpu(input string tag, input logic valid, input logic [31:0] addr,
                          input logic [31:0] line);
    checkVal({tag, ".valid"}, {31'd0, cpu_rspInsLineValidOut}, {31'd0, valid});
    checkVal({tag, ".addr"}, cpu_rspAddrOut, addr);
    checkVal({tag, ".line"}, cpu_rspInsLineOut, line);
  endtask

  task automatic checkMem(input string tag, input logic valid, input logic [5:0] mtag);
    checkVal({tag, ".reqValid"}, {31'd0, mem_reqTagValidOut}, {31'd0, valid});
    if (valid) checkVal({tag, ".reqTag"}, {26'd0, mem_reqTagOut}, {26'd0, mtag});
  endtask

  task automatic setFill(input logic v, input logic [5:0] t, input logic [31:0] d);
    mem_rspInsLineValidIn = v;
    mem_rspTagIn          = t;
    mem_rspInsLineIn      = d;
  endtask

  initial begin
    Rst = 1'b0;
    cpu_reqAddrIn = 32'h0;
    setFill(1'b0, 6'd0, 32'h0);

    // Reset state
    tick(); tick();
    checkCpu("reset", 1'b0, 32'h0, 32'h0);
    checkVal("reset.reqValid", {31'd0, mem_reqTagValidOut}, 32'd0);
    checkVal("reset.reqTag", {26'd0, mem_reqTagOut}, 32'd0);

    // First miss on address 0
    Rst = 1'b1;
    tick();
    checkCpu("miss0", 1'b0, 32'h0, 32'h0);
    checkMem("miss0", 1'b1, 6'd0);

    // Fill tag 0 with address held: bypass hit, request drops
    setFill(1'b1, 6'd0, 32'hDEADBEEF);
    tick();
    checkCpu("fill0", 1'b1, 32'h0, 32'hDEADBEEF);
    checkMem("fill0", 1'b0, 6'd0);
    setFill(1'b0, 6'd0, 32'h0);
    tick();
    checkCpu("hit0", 1'b1, 32'h0, 32'hDEADBEEF);

    // Miss on tag 2; a fill with another tag does not end WAIT
    cpu_reqAddrIn = 32'h40;
    tick();
    checkCpu("miss2", 1'b0, 32'h0, 32'hDEADBEEF);
    checkMem("miss2", 1'b1, 6'd2);
    setFill(1'b1, 6'd1, 32'h12345678);
    tick();
    checkCpu("other1", 1'b0, 32'h0, 32'hDEADBEEF);
    checkMem("other1", 1'b1, 6'd2);
    setFill(1'b1, 6'd2, 32'hCAFEBABE);
    tick();
    checkCpu("fill2", 1'b1, 32'h40, 32'hCAFEBABE);
    checkMem("fill2", 1'b0, 6'd0);

    // Fill tags 3 and 4: entries full, tag 0 evicted round-robin
    setFill(1'b1, 6'd3, 32'h33333333);
    tick();
    checkCpu("fill3", 1'b1, 32'h40, 32'hCAFEBABE);
    setFill(1'b1, 6'd4, 32'h44444444);
    tick();
    checkCpu("fill4", 1'b1, 32'h40, 32'hCAFEBABE);
    setFill(1'b0, 6'd0, 32'h0);
    cpu_reqAddrIn = 32'h0;
    tick();
    checkCpu("evict0", 1'b0, 32'h40, 32'hCAFEBABE);
    checkMem("evict0", 1'b1, 6'd0);
    cpu_reqAddrIn = 32'h80;
    tick();
    checkCpu("hit4wait", 1'b1, 32'h80, 32'h44444444);
    checkMem("hit4wait", 1'b1, 6'd0);
    // Refill tag 0 (replaces tag 1 at pointer 1) to close WAIT
    setFill(1'b1, 6'd0, 32'h00000A0A);
    tick();
    checkCpu("refill0", 1'b1, 32'h80, 32'h44444444);
    checkMem("refill0", 1'b0, 6'd0);

    // Fill valid held with tag 3 for three cycles: updated in place
    cpu_reqAddrIn = 32'h60;
    setFill(1'b1, 6'd3, 32'h3C3C3C3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCpu($sformatf("hold3_%0d", i), 1'b1, 32'h60, 32'h3C3C3C3C);
      checkMem($sformatf("hold3_%0d", i), 1'b0, 6'd0);
    end
    setFill(1'b0, 6'd0, 32'h0);
    cpu_reqAddrIn = 32'h0;
    tick();
    checkCpu("res0", 1'b1, 32'h0, 32'h00000A0A);
    cpu_reqAddrIn = 32'h40;
    tick();
    checkCpu("res2", 1'b1, 32'h40, 32'hCAFEBABE);
    cpu_reqAddrIn = 32'h80;
    tick();
    checkCpu("res4", 1'b1, 32'h80, 32'h44444444);
    cpu_reqAddrIn = 32'h60;
    tick();
    checkCpu("res3", 1'b1, 32'h60, 32'h3C3C3C3C);
    // High address bits alias onto tag 0
    cpu_reqAddrIn = 32'h80000000;
    tick();
    checkCpu("alias0", 1'b1, 32'h80000000, 32'h00000A0A);
    checkMem("alias0", 1'b0, 6'd0);

    // Reset while waiting on tag 5
    cpu_reqAddrIn = 32'hA0;
    tick();
    checkCpu("miss5", 1'b0, 32'h80000000, 32'h00000A0A);
    checkMem("miss5", 1'b1, 6'd5);
    Rst = 1'b0;
    tick();
    checkCpu("rstwait", 1'b0, 32'h0, 32'h0);
    checkVal("rstwait.reqValid", {31'd0, mem_reqTagValidOut}, 32'd0);
    checkVal("rstwait.reqTag", {26'd0, mem_reqTagOut}, 32'd0);
    Rst = 1'b1;
    cpu_reqAddrIn = 32'h0;
    tick();
    checkCpu("postrst", 1'b0, 32'h0, 32'h0);
    checkMem("postrst", 1'b1, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
